// File: rtl/mdiv32_if.sv
// Handshake and result bundle between the execution stage and the divider.
interface mdiv32_if;
    logic        start;
    logic        signed_op;
    logic        abort;
    logic [31:0] din_a;
    logic [31:0] din_b;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        qnzout;
    logic        vout;
    logic        dbz;

    modport master (
        output start, signed_op, abort, din_a, din_b,
        input  quotient, remainder, busy, done, qnzout, vout, dbz
    );

    modport slave (
        input  start, signed_op, abort, din_a, din_b,
        output quotient, remainder, busy, done, qnzout, vout, dbz
    );
endinterface

// File: rtl/mdiv32.sv
// Sequential 32-bit restoring divider, one quotient bit per clock.
//
//   state | meaning
//   IDLE  | waiting for start; operands and signs latched on start
//   CALC  | 32 restoring steps, MSB-first, step count in r_cnt
//   FIX   | apply result signs, load output registers and flags
//   DONE  | one-cycle done pulse, then back to IDLE
module mdiv32 (
    input  logic     clk,
    input  logic     reset_b,
    mdiv32_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [32:0] r_rem;
    logic [31:0] r_dq;
    logic [31:0] r_div;
    logic        r_qsign;
    logic        r_rsign;
    logic        r_ovf;
    logic [31:0] r_quotient;
    logic [31:0] r_remainder;
    logic        r_busy;
    logic        r_done;
    logic        r_qnz;
    logic        r_vout;
    logic        r_dbz;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [33:0] w_shift;
    logic [33:0] w_trial;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_abs_a = (bus.signed_op && bus.din_a[31]) ? (~bus.din_a + 32'd1) : bus.din_a;
    assign w_abs_b = (bus.signed_op && bus.din_b[31]) ? (~bus.din_b + 32'd1) : bus.din_b;

    // r_dq holds the unconsumed dividend bits at the top and collects quotient bits at the bottom.
    // The trial is one bit wider than the shifted remainder so its MSB is a true borrow.
    assign w_shift = {r_rem, r_dq[31]};
    assign w_trial = w_shift - {2'b00, r_div};

    assign w_q_fix = r_qsign ? (~r_dq + 32'd1) : r_dq;
    assign w_r_fix = r_rsign ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

    // Sequencer, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state     <= IDLE;
            r_cnt       <= 5'd0;
            r_rem       <= 33'd0;
            r_dq        <= 32'd0;
            r_div       <= 32'd0;
            r_qsign     <= 1'b0;
            r_rsign     <= 1'b0;
            r_ovf       <= 1'b0;
            r_quotient  <= 32'd0;
            r_remainder <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_qnz       <= 1'b0;
            r_vout      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        if (bus.din_b == 32'd0) begin
                            r_quotient  <= 32'hFFFF_FFFF;
                            r_remainder <= bus.din_a;
                            r_dbz       <= 1'b1;
                            r_vout      <= 1'b0;
                            r_qnz       <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_dq    <= w_abs_a;
                            r_div   <= w_abs_b;
                            r_qsign <= bus.signed_op & (bus.din_a[31] ^ bus.din_b[31]);
                            r_rsign <= bus.signed_op & bus.din_a[31];
                            r_ovf   <= bus.signed_op && (bus.din_a == 32'h8000_0000) &&
                                       (bus.din_b == 32'hFFFF_FFFF);
                            r_rem   <= 33'd0;
                            r_cnt   <= 5'd0;
                            r_busy  <= 1'b1;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        if (!w_trial[33]) begin
                            r_rem <= w_trial[32:0];
                        end else begin
                            r_rem <= w_shift[32:0];
                        end
                        r_dq  <= {r_dq[30:0], ~w_trial[33]};
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (bus.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_quotient  <= w_q_fix;
                        r_remainder <= w_r_fix;
                        r_qnz       <= |w_q_fix;
                        r_dbz       <= 1'b0;
                        r_vout      <= r_ovf;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.qnzout    = r_qnz;
    assign bus.vout      = r_vout;
    assign bus.dbz       = r_dbz;
endmodule

// File: tb/tb_mdiv32.sv
// Directed and randomized checks for the mdiv32 sequential divider.
module tb_mdiv32;
    logic clk;
    logic reset_b;
    int   errs;
    int   n_chk;
    int   overlap;

    mdiv32_if u_if ();

    mdiv32 dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        qnz;
        logic        v;
        logic        z;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one start pulse; returns at the falling edge after the sampling edge E0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        u_if.din_a     = a;
        u_if.din_b     = b;
        u_if.signed_op = s;
        u_if.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.start = 1'b0;
    endtask

    // lat counts edges since E0 at the moment done is seen; 99 means it never came.
    task automatic wait_done(input int lat0, output int lat, output int bcyc);
        lat  = lat0;
        bcyc = 0;
        while (!u_if.done && lat < 60) begin
            if (u_if.busy) bcyc++;
            @(negedge clk);
            lat++;
        end
        if (u_if.busy && u_if.done) overlap++;
        if (!u_if.done) lat = 99;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output int lat, output int bcyc);
        start_op(a, b, s);
        wait_done(1, lat, bcyc);
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    vec_t vecs[13];

    initial begin
        int lat;
        int bcyc;
        int dcnt;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] eq;
        logic [31:0] er;
        logic        es;

        errs    = 0;
        n_chk   = 0;
        overlap = 0;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b1, 1'b0, 1'b0, 34};
        vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0, 34};
        vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b1, 1'b0, 1'b0, 34};
        vecs[3]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b1, 1'b0, 1'b0, 34};
        vecs[4]  = '{32'd1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'd1234,       1'b1, 1'b0, 1'b1, 1};
        vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b1, 1'b1, 1'b0, 34};
        vecs[6]  = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          1'b0, 1'b0, 1'b0, 34};
        vecs[7]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 1'b0, 34};
        vecs[8]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b1, 1'b0, 1'b0, 34};
        vecs[9]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b1, 1'b0, 1'b0, 34};
        vecs[10] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 1'b0, 1'b1, 1};
        vecs[11] = '{32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  32'd0,          1'b1, 1'b0, 1'b0, 34};
        vecs[12] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0, 1'b0, 1'b0, 34};

        u_if.start     = 1'b0;
        u_if.signed_op = 1'b0;
        u_if.abort     = 1'b0;
        u_if.din_a     = 32'd0;
        u_if.din_b     = 32'd0;
        reset_b        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_quotient", u_if.quotient, 32'd0);
        chk("rst_remainder", u_if.remainder, 32'd0);
        chk("rst_flags", {27'd0, u_if.busy, u_if.done, u_if.qnzout, u_if.vout, u_if.dbz}, 32'd0);
        reset_b = 1'b1;
        @(negedge clk);

        // Directed vectors, one IDLE cycle between operations.
        for (int i = 0; i < 13; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].s, lat, bcyc);
            chk($sformatf("v%0d_quotient", i), u_if.quotient, vecs[i].q);
            chk($sformatf("v%0d_remainder", i), u_if.remainder, vecs[i].r);
            chk($sformatf("v%0d_qnzout", i), {31'd0, u_if.qnzout}, {31'd0, vecs[i].qnz});
            chk($sformatf("v%0d_vout", i), {31'd0, u_if.vout}, {31'd0, vecs[i].v});
            chk($sformatf("v%0d_dbz", i), {31'd0, u_if.dbz}, {31'd0, vecs[i].z});
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            if (i == 0) chk("v0_busy_cycles", bcyc, 33);
            @(negedge clk);
        end

        // Start held through the DONE cycle is ignored.
        run_div(32'd40, 32'd5, 1'b0, lat, bcyc);
        chk("done_seq_q", u_if.quotient, 32'd8);
        start_op(32'd999, 32'd3, 1'b0);
        chk("start_in_done_busy", {31'd0, u_if.busy}, 32'd0);
        chk("start_in_done_done", {31'd0, u_if.done}, 32'd0);
        chk("start_in_done_hold_q", u_if.quotient, 32'd8);

        // Second start at step 10 must not disturb the division in flight.
        start_op(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        u_if.din_a     = 32'd1000;
        u_if.din_b     = 32'd3;
        u_if.signed_op = 1'b1;
        u_if.start     = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        wait_done(11, lat, bcyc);
        chk("restart_quotient", u_if.quotient, 32'd14);
        chk("restart_remainder", u_if.remainder, 32'd2);
        chk("restart_latency", lat, 34);
        @(negedge clk);

        // Abort at step 20: no done, outputs keep 100/7 result, then a fresh start works.
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (19) @(negedge clk);
        u_if.abort = 1'b1;
        @(negedge clk);
        u_if.abort = 1'b0;
        chk("abort_busy", {31'd0, u_if.busy}, 32'd0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (u_if.done || u_if.busy) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        chk("abort_hold_q", u_if.quotient, 32'd14);
        chk("abort_hold_r", u_if.remainder, 32'd2);
        run_div(32'd1000, 32'd3, 1'b0, lat, bcyc);
        chk("post_abort_q", u_if.quotient, 32'd333);
        chk("post_abort_r", u_if.remainder, 32'd1);
        chk("post_abort_latency", lat, 34);
        @(negedge clk);

        // Asynchronous reset mid-CALC clears outputs without a clock edge.
        start_op(32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        #2 reset_b = 1'b0;
        #1;
        chk("async_rst_q", u_if.quotient, 32'd0);
        chk("async_rst_r", u_if.remainder, 32'd0);
        chk("async_rst_flags", {27'd0, u_if.busy, u_if.done, u_if.qnzout, u_if.vout, u_if.dbz}, 32'd0);
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        run_div(32'd5, 32'd10, 1'b0, lat, bcyc);
        chk("post_rst_q", u_if.quotient, 32'd0);
        chk("post_rst_r", u_if.remainder, 32'd5);
        chk("post_rst_qnz", {31'd0, u_if.qnzout}, 32'd0);
        @(negedge clk);

        // Random back-to-back operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            ea = $urandom;
            case (i % 4)
                0: eb = $urandom;
                1: eb = $urandom_range(1, 1000);
                2: eb = 32'hFFFF_FFFF - $urandom_range(0, 20);
                default: eb = (i % 20 == 3) ? 32'd0 : $urandom_range(1, 65535);
            endcase
            if (i % 50 == 7) begin
                ea = 32'h8000_0000;
                eb = 32'hFFFF_FFFF;
            end
            es = i[0];
            ref_div(ea, eb, es, eq, er);
            run_div(ea, eb, es, lat, bcyc);
            chk($sformatf("rnd%0d_q a=%h b=%h s=%0d", i, ea, eb, es), u_if.quotient, eq);
            chk($sformatf("rnd%0d_r a=%h b=%h s=%0d", i, ea, eb, es), u_if.remainder, er);
            chk($sformatf("rnd%0d_lat", i), lat, (eb == 32'd0) ? 1 : 34);
            @(negedge clk);
        end

        chk("busy_done_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end
endmodule
